ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_VEC, 32'h0000_0000, PC value loaded after reset.
REQ-002 Parameter DEPTH, 2, maximum in-flight plus buffered fetches; fixed at 2.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pc_cur  in  32  current PC from the PC register; address of the next fetch.
REQ-006 pc_jmp / pc_rel / pc_diff[31:0] / pc_nxt[31:0]  out  PC control: hold, advance or load.
REQ-007 redir_valid  in  1  redirect request from execute.
REQ-008 redir_target  in  32  absolute redirect address.
REQ-009 imem_req_valid / imem_req_ready  out/in  1  request handshake.
REQ-010 imem_req_addr  out  32  request address, equal to pc_cur.
REQ-011 imem_resp_valid / imem_resp_data[31:0]  in  in-order responses, no backpressure.
REQ-012 if_valid / if_ready  out/in  1  instruction handshake to decode.
REQ-013 if_instr / if_pc  out  32 each  fetched word and its address.

Function
REQ-014 The PC control outputs SHALL encode: advance = jmp 0; hold = jmp 1, rel 1, diff 0; load = jmp 1, rel 0, nxt = address.
REQ-015 FSM states SHALL be S_BOOT, S_RUN and S_DRAIN.
REQ-016 S_BOOT SHALL be held for 1 cycle after reset, drive load RESET_VEC, issue no request, and then go to S_RUN.
REQ-017 In S_RUN, imem_req_valid SHALL be high when live + kill_cnt + fifo_count < 2, there is no redirect, and the state is not S_BOOT.
REQ-018 A request accept (valid && ready) SHALL advance the PC (+4 in the PC block) and push pc_cur into the address queue.
REQ-019 With no accept and no redirect, the PC SHALL be driven to hold.
REQ-020 A redirect SHALL have top priority in every state:
- drive load redir_target and suppress the request that cycle.
- flush the response FIFO.
- set kill_cnt = live minus any response arriving that same cycle.
- go to S_DRAIN if kill_cnt is nonzero, otherwise S_RUN.
REQ-021 A response arriving while kill_cnt > 0 SHALL be dropped; kill_cnt decrements and the address queue pops.
REQ-022 In S_DRAIN no request SHALL issue; when kill_cnt reaches 0, the FSM SHALL go to S_RUN.
REQ-023 A live response SHALL pop the address queue and push {pc, data} into the response FIFO in the same cycle.
REQ-024 The response FIFO SHALL be first-word fall-through: if_valid = not empty, and if_instr/if_pc come from the head entry.
REQ-025 A decode handshake in the same cycle as a redirect SHALL complete; the flush applies to the remaining entries only.
REQ-026 A simultaneous push and pop on the response FIFO SHALL be legal at any occupancy.
REQ-027 The credit rule SHALL make overflow impossible; a response with no outstanding request is illegal and asserted in simulation.
REQ-028 All counters SHALL be 2 bits; PC arithmetic SHALL wrap modulo 2^32.

Reset
REQ-029 While rst is high:
- state = S_BOOT, kill_cnt = 0, FIFOs empty.
- if_valid = 0, imem_req_valid = 0.
- pc_jmp = 1, pc_rel = 0, pc_nxt = RESET_VEC, pc_diff = 0.
REQ-030 Reset mid-operation SHALL discard all outstanding and buffered state; late responses after reset SHALL be ignored until the first request issues.

Structure
REQ-031 The state enum, the DEPTH constant and RESET_VEC SHALL live in the shared def package.
REQ-032 A sub-module fifo2 (2-entry, parameterised width, flush input) SHALL be instantiated twice: address queue (32 bits) and response FIFO (64 bits).

Verification
REQ-033 Reset release, imem_req_ready=1, 1-cycle response latency, if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8 with matching data.
REQ-034 imem_req_ready held 0 for 3 cycles -> pc held at 0x8 and no push; request 0x8 issues on the first ready cycle.
REQ-035 if_ready=0 with 2 fetches buffered -> imem_req_valid=0 and PC held; one if_ready pulse -> exactly one new request.
REQ-036 Redirect to 0x100 with 2 live requests -> both responses dropped, S_DRAIN for 2 responses, then the next if_pc is 0x100.
REQ-037 Redirect in the same cycle as a response and a decode handshake -> handshake completes, response dropped, kill_cnt = 1.
REQ-038 rst asserted with FIFOs full -> outputs at reset values immediately; after release, first request address is RESET_VEC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, fetch depth
// and the default boot address.
package ifetch_pkg;

  localparam int unsigned DEF_DEPTH     = 2;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

endpackage

// File: rtl/ifetch_fifo2.sv
// Two-entry first-word-fall-through FIFO with a synchronous flush; the head
// entry is visible on o_data whenever the FIFO is not empty.
module fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign w_push  = i_push && ((r_count != 2'd2) || w_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues one request per free credit, tags responses with
// their address, buffers them for decode and discards work killed by redirects.
module ifetch #(
  parameter logic [31:0] RESET_VEC = ifetch_pkg::DEF_RESET_VEC,
  parameter int unsigned DEPTH     = ifetch_pkg::DEF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc_cur,
  output logic        o_pc_jmp,
  output logic        o_pc_rel,
  output logic [31:0] o_pc_diff,
  output logic [31:0] o_pc_nxt,
  input  logic        i_redir_valid,
  input  logic [31:0] i_redir_target,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  output logic        o_if_valid,
  input  logic        i_if_ready,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc
);

  import ifetch_pkg::*;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  r_kill;
  logic [1:0]  w_kill_nxt;
  logic        r_armed;
  logic [1:0]  w_aq_count;
  logic        w_aq_empty;
  logic [31:0] w_aq_head;
  logic [1:0]  w_rf_count;
  logic        w_rf_empty;
  fetch_t      w_rf_head;
  fetch_t      w_rf_in;
  logic        w_credit;
  logic        w_accept;
  logic        w_resp;
  logic        w_drop;
  logic        w_live_resp;
  logic        w_if_pop;

  // The address queue holds every outstanding request, live or killed.
  assign w_credit    = ({1'b0, w_aq_count} + {1'b0, w_rf_count}) < 3'(DEPTH);
  assign w_accept    = o_imem_req_valid && i_imem_req_ready;
  assign w_resp      = i_imem_resp_valid && !w_aq_empty;
  assign w_drop      = w_resp && (r_kill != 2'd0);
  assign w_live_resp = w_resp && (r_kill == 2'd0) && !i_redir_valid;
  assign w_if_pop    = o_if_valid && i_if_ready;
  assign w_rf_in     = '{pc: w_aq_head, instr: i_imem_resp_data};

  assign o_imem_req_addr = i_pc_cur;
  assign o_if_valid      = !w_rf_empty;
  assign o_if_instr      = w_rf_head.instr;
  assign o_if_pc         = w_rf_head.pc;

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_kill_nxt       = r_kill - {1'b0, w_drop};
    o_pc_jmp         = 1'b1;
    o_pc_rel         = 1'b1;
    o_pc_diff        = '0;
    o_pc_nxt         = '0;
    o_imem_req_valid = 1'b0;
    if (i_redir_valid) begin
      o_pc_rel    = 1'b0;
      o_pc_nxt    = i_redir_target;
      w_kill_nxt  = w_aq_count - {1'b0, w_resp};
      w_state_nxt = (w_kill_nxt != 2'd0) ? S_DRAIN : S_RUN;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          o_pc_rel    = 1'b0;
          o_pc_nxt    = RESET_VEC;
          w_state_nxt = S_RUN;
        end
        S_RUN: begin
          o_imem_req_valid = w_credit;
          if (w_credit && i_imem_req_ready) o_pc_jmp = 1'b0;
        end
        S_DRAIN: begin
          if (w_kill_nxt == 2'd0) w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_kill  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
      if (w_accept) r_armed <= 1'b1;
    end
  end

  fifo2 #(.W(32)) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (1'b0),
    .i_push  (w_accept),
    .i_data  (i_pc_cur),
    .i_pop   (w_resp),
    .o_data  (w_aq_head),
    .o_empty (w_aq_empty),
    .o_count (w_aq_count)
  );

  fifo2 #(.W($bits(fetch_t))) u_resp_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_redir_valid),
    .i_push  (w_live_resp),
    .i_data  (w_rf_in),
    .i_pop   (w_if_pop),
    .o_data  (w_rf_head),
    .o_empty (w_rf_empty),
    .o_count (w_rf_count)
  );

  // Once a request has issued, a response with nothing outstanding is a memory bug.
  a_resp_has_req : assert property (@(posedge clk) disable iff (rst)
    (i_imem_resp_valid && r_armed) |-> !w_aq_empty);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a PC register and in-order instruction memory
// model around the DUT, with hand-computed expected fetch sequences.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_pc_cur;
  logic        o_pc_jmp, o_pc_rel;
  logic [31:0] o_pc_diff, o_pc_nxt;
  logic        i_redir_valid;
  logic [31:0] i_redir_target;
  logic        o_imem_req_valid, i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_resp_valid;
  logic [31:0] i_imem_resp_data;
  logic        o_if_valid, i_if_ready;
  logic [31:0] o_if_instr, o_if_pc;

  always #5 clk = ~clk;

  ifetch dut (
    .clk               (clk),
    .rst               (rst),
    .i_pc_cur          (i_pc_cur),
    .o_pc_jmp          (o_pc_jmp),
    .o_pc_rel          (o_pc_rel),
    .o_pc_diff         (o_pc_diff),
    .o_pc_nxt          (o_pc_nxt),
    .i_redir_valid     (i_redir_valid),
    .i_redir_target    (i_redir_target),
    .o_imem_req_valid  (o_imem_req_valid),
    .i_imem_req_ready  (i_imem_req_ready),
    .o_imem_req_addr   (o_imem_req_addr),
    .i_imem_resp_valid (i_imem_resp_valid),
    .i_imem_resp_data  (i_imem_resp_data),
    .o_if_valid        (o_if_valid),
    .i_if_ready        (i_if_ready),
    .o_if_instr        (o_if_instr),
    .o_if_pc           (o_if_pc)
  );

  logic [31:0] q[$];
  bit          auto_resp;
  int          n_acc;
  int          n_checks;
  int          n_pass;
  int          acc0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic check_hold(input string tag);
    check({tag, " jmp"}, o_pc_jmp, 1);
    check({tag, " rel"}, o_pc_rel, 1);
    check({tag, " diff"}, o_pc_diff, 0);
  endtask

  // Memory contents: word at address a is a ^ 32'hDEAD_0000.
  task automatic present();
    i_imem_resp_valid = auto_resp && (q.size() > 0);
    i_imem_resp_data  = (q.size() > 0) ? (q[0] ^ 32'hDEAD_0000) : 32'h0;
  endtask

  task automatic tick();
    logic        acc, took, jmp, rel;
    logic [31:0] addr, diff, nxt;
    #1;
    acc  = o_imem_req_valid && i_imem_req_ready;
    took = i_imem_resp_valid;
    addr = o_imem_req_addr;
    jmp  = o_pc_jmp;
    rel  = o_pc_rel;
    diff = o_pc_diff;
    nxt  = o_pc_nxt;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (took && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(addr);
        n_acc++;
      end
    end
    i_pc_cur = jmp ? (rel ? i_pc_cur + diff : nxt) : i_pc_cur + 32'd4;
    present();
  endtask

  task automatic do_reset(input bit late);
    rst               = 1'b1;
    i_redir_valid     = 1'b0;
    i_imem_resp_valid = 1'b0;
    auto_resp         = 1'b1;
    q.delete();
    #1;
    check("rst if_valid", o_if_valid, 0);
    check("rst req_valid", o_imem_req_valid, 0);
    check("rst jmp", o_pc_jmp, 1);
    check("rst rel", o_pc_rel, 0);
    check("rst nxt", o_pc_nxt, 32'h0);
    check("rst diff", o_pc_diff, 0);
    tick();
    tick();
    rst = 1'b0;
    if (late) begin
      i_imem_resp_valid = 1'b1;
      i_imem_resp_data  = 32'hBAD0_BAD0;
    end
    #1;
    check("boot req_valid", o_imem_req_valid, 0);
    check("boot jmp", o_pc_jmp, 1);
    check("boot rel", o_pc_rel, 0);
    check("boot nxt", o_pc_nxt, 32'h0);
    tick();
  endtask

  task automatic expect_if(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    int n = 0;
    while (!o_if_valid && n < 16) begin
      tick();
      n++;
    end
    check({tag, " valid"}, o_if_valid, 1);
    check({tag, " pc"}, o_if_pc, pc);
    check({tag, " instr"}, o_if_instr, instr);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    i_pc_cur          = 32'hFFFF_FFF0;
    i_imem_req_ready  = 1'b1;
    i_if_ready        = 1'b1;
    i_redir_valid     = 1'b0;
    i_redir_target    = 32'h0;
    i_imem_resp_valid = 1'b0;
    i_imem_resp_data  = 32'h0;
    auto_resp         = 1'b1;

    // Boot and straight-line fetch, then an imem stall.
    do_reset(1'b0);
    check("first req valid", o_imem_req_valid, 1);
    check("first req addr", o_imem_req_addr, 32'h0);
    expect_if("f0", 32'h0, 32'hDEAD_0000);
    i_imem_req_ready = 1'b0;
    #1;
    check("stall req_valid", o_imem_req_valid, 1);
    check("stall pc", i_pc_cur, 32'h8);
    check_hold("stall0");
    expect_if("f1", 32'h4, 32'hDEAD_0004);
    for (int i = 1; i < 3; i++) begin
      check("stall pc", i_pc_cur, 32'h8);
      check("stall addr", o_imem_req_addr, 32'h8);
      check_hold("stall");
      check("stall no fetch", o_if_valid, 0);
      tick();
    end
    i_imem_req_ready = 1'b1;
    #1;
    check("resume addr", o_imem_req_addr, 32'h8);
    check("resume advance", o_pc_jmp, 0);
    expect_if("f2", 32'h8, 32'hDEAD_0008);

    // Decode backpressure with both slots buffered.
    i_if_ready = 1'b0;
    repeat (4) tick();
    check("full if_pc", o_if_pc, 32'hC);
    check("full req_valid", o_imem_req_valid, 0);
    check_hold("full");
    check("full pc", i_pc_cur, 32'h14);
    acc0 = n_acc;
    i_if_ready = 1'b1;
    #1;
    check("pulse instr", o_if_instr, 32'hDEAD_000C);
    tick();
    i_if_ready = 1'b0;
    repeat (4) tick();
    check("one new req", 32'(n_acc - acc0), 1);
    check("after pulse if_pc", o_if_pc, 32'h10);
    check("after pulse req_valid", o_imem_req_valid, 0);
    check("after pulse pc", i_pc_cur, 32'h18);

    // Redirect with two live requests: both responses dropped.
    do_reset(1'b0);
    auto_resp  = 1'b0;
    i_if_ready = 1'b1;
    tick();
    tick();
    check("two live req_valid", o_imem_req_valid, 0);
    i_redir_valid  = 1'b1;
    i_redir_target = 32'h100;
    #1;
    check("redir jmp", o_pc_jmp, 1);
    check("redir rel", o_pc_rel, 0);
    check("redir nxt", o_pc_nxt, 32'h100);
    check("redir req_valid", o_imem_req_valid, 0);
    tick();
    i_redir_valid = 1'b0;
    #1;
    check("drain req_valid", o_imem_req_valid, 0);
    tick();
    check("drain wait req_valid", o_imem_req_valid, 0);
    auto_resp = 1'b1;
    present();
    #1;
    check("drop0 req_valid", o_imem_req_valid, 0);
    tick();
    check("drop1 req_valid", o_imem_req_valid, 0);
    check("drop1 if_valid", o_if_valid, 0);
    tick();
    check("post drain valid", o_imem_req_valid, 1);
    check("post drain addr", o_imem_req_addr, 32'h100);
    expect_if("redir target", 32'h100, 32'hDEAD_0100);

    // Redirect coinciding with a response: exactly one response left to kill.
    do_reset(1'b0);
    auto_resp = 1'b0;
    tick();
    tick();
    auto_resp = 1'b1;
    present();
    i_redir_valid  = 1'b1;
    i_redir_target = 32'h200;
    #1;
    check("redir+resp nxt", o_pc_nxt, 32'h200);
    check("redir+resp req_valid", o_imem_req_valid, 0);
    tick();
    i_redir_valid = 1'b0;
    #1;
    check("kill1 req_valid", o_imem_req_valid, 0);
    check("kill1 if_valid", o_if_valid, 0);
    tick();
    check("kill1 done valid", o_imem_req_valid, 1);
    check("kill1 done addr", o_imem_req_addr, 32'h200);
    expect_if("kill1 target", 32'h200, 32'hDEAD_0200);

    // Redirect with a decode handshake and a response in the same cycle.
    do_reset(1'b0);
    i_if_ready = 1'b0;
    tick();
    tick();
    i_if_ready     = 1'b1;
    i_redir_valid  = 1'b1;
    i_redir_target = 32'h300;
    #1;
    check("hs if_valid", o_if_valid, 1);
    check("hs if_pc", o_if_pc, 32'h0);
    check("hs req_valid", o_imem_req_valid, 0);
    tick();
    i_redir_valid = 1'b0;
    #1;
    check("hs flushed if_valid", o_if_valid, 0);
    check("hs no drain req_valid", o_imem_req_valid, 1);
    check("hs addr", o_imem_req_addr, 32'h300);
    expect_if("hs target", 32'h300, 32'hDEAD_0300);

    // Reset with both FIFOs full, plus a stale response after release.
    do_reset(1'b0);
    i_if_ready = 1'b0;
    repeat (4) tick();
    check("prefull if_valid", o_if_valid, 1);
    check("prefull req_valid", o_imem_req_valid, 0);
    do_reset(1'b1);
    i_if_ready = 1'b1;
    check("post-rst if_valid", o_if_valid, 0);
    check("post-rst req_valid", o_imem_req_valid, 1);
    check("post-rst addr", o_imem_req_addr, 32'h0);
    expect_if("post-rst f0", 32'h0, 32'hDEAD_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
